pipeline_adder_accumulator: RTL and testbench

//   Downstream consumer of the 2-stage pipelined 8-bit adder. Takes each {cout,sum} result
//   as a 9-bit unsigned value and accumulates BLOCK_LEN results into one ACC_W-bit total.

---
 rtl/pipeline_adder_pkg.sv | 18 +
 rtl/pipeline_adder_accumulator_if.sv | 24 ++
 rtl/pipeline_adder_accumulator_acc_add_unit.sv | 23 ++
 rtl/pipeline_adder_accumulator.sv | 115 +++++++++++
 tb/tb_pipeline_adder_accumulator.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_adder_pkg.sv
// Shared types and defaults for the adder-result accumulator.
package pipeline_adder_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int DATA_W_DEF    = 8;
  localparam int ACC_W_DEF     = 16;
  localparam int BLOCK_LEN_DEF = 4;

  // An adder result is the sum plus its carry-out.
  function automatic int val_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/pipeline_adder_accumulator_if.sv
// Input (adder result) and output (block total) valid/ready channels of the accumulator.
interface pipeline_adder_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_sum;
  logic              in_cout;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;

  modport master (
    output in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/pipeline_adder_accumulator_acc_add_unit.sv
// Combinational accumulate step: acc + v with overflow detect.
// Build option ACC_SAT_EN: clamp to all-ones on overflow instead of wrapping.
module acc_add_unit #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] i_v,
  output logic [ACC_W-1:0] o_next_acc,
  output logic             o_ovf
);
  logic [ACC_W:0] w_sum;

  assign w_sum = {1'b0, i_acc} + {1'b0, i_v};
  assign o_ovf = w_sum[ACC_W];

`ifdef ACC_SAT_EN
  // Once clamped, any further non-zero add overflows again, so the total stays pinned.
  assign o_next_acc = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign o_next_acc = w_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/pipeline_adder_accumulator.sv
// Accumulates BLOCK_LEN adder results into one total presented on a valid/ready output.
// Build option ACC_SAT_EN (in acc_add_unit) selects saturating instead of wrapping totals.
module pipeline_adder_accumulator
  import pipeline_adder_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BLOCK_LEN = BLOCK_LEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_adder_accumulator_if.slave  bus
);
  localparam int VAL_W = val_width(DATA_W);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic [VAL_W-1:0] w_val;
  logic [ACC_W-1:0] w_v;
  logic [ACC_W-1:0] w_add_acc;
  logic             w_add_ovf;
  logic             w_in_ready;
  logic             w_in_fire;

  assign w_val = {bus.in_cout, bus.in_sum};
  assign w_v   = ACC_W'(w_val);

  acc_add_unit #(.ACC_W(ACC_W)) u_add (
    .i_acc      (r_acc),
    .i_v        (w_v),
    .o_next_acc (w_add_acc),
    .o_ovf      (w_add_ovf)
  );

  // In HOLD the input is only taken when the finished block is handed off in the same cycle.
  assign w_in_ready    = !rst && ((r_state == ST_ACC) || bus.out_ready);
  assign w_in_fire     = bus.in_valid && w_in_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.out_data  = r_acc;
  assign bus.out_ovf   = r_ovf;

  // Next-state, accumulator, counter and overflow decode.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      ST_ACC: begin
        if (w_in_fire) begin
          w_acc_nxt = w_add_acc;
          w_ovf_nxt = r_ovf | w_add_ovf;
          if (r_cnt == CNT_W'(BLOCK_LEN - 1)) begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = ST_HOLD;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready && bus.in_valid) begin
          w_acc_nxt = w_v;
          w_ovf_nxt = 1'b0;
          if (BLOCK_LEN == 1) begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = ST_HOLD;
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_ACC;
          end
        end else if (bus.out_ready) begin
          w_acc_nxt   = {ACC_W{1'b0}};
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = ST_ACC;
        end else begin
          w_acc_nxt = r_acc;
        end
      end
      default: begin
        w_state_nxt = ST_ACC;
        w_acc_nxt   = {ACC_W{1'b0}};
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_ovf_nxt   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_acc   <= {ACC_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pipeline_adder_accumulator.sv
// Directed-vector bench: default, ACC_W=10 and BLOCK_LEN=1 instances of the accumulator.
module tb_pipeline_adder_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  always #5 clk = ~clk;

  pipeline_adder_accumulator_if #(.DATA_W(8), .ACC_W(16)) bus_a ();
  pipeline_adder_accumulator_if #(.DATA_W(8), .ACC_W(10)) bus_b ();
  pipeline_adder_accumulator_if #(.DATA_W(8), .ACC_W(16)) bus_c ();

  pipeline_adder_accumulator #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  pipeline_adder_accumulator #(.DATA_W(8), .ACC_W(10), .BLOCK_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  pipeline_adder_accumulator #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(1)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    vec_cnt++;
    if (bus_a.in_ready !== 1'b0) begin
      miss_cnt++; $display("FAIL rst_in_ready got %b exp 0", bus_a.in_ready);
    end
    vec_cnt++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 16'd0 || bus_a.out_ovf !== 1'b0) begin
      miss_cnt++;
      $display("FAIL rst_outputs got v=%b d=%0d o=%b exp 0/0/0",
               bus_a.out_valid, bus_a.out_data, bus_a.out_ovf);
    end
    vec_cnt++;
    if (bus_c.out_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL rst_c_out_valid got %b exp 0", bus_c.out_valid);
    end
    rst = 1'b0;
    tick;
    vec_cnt++;
    if (bus_a.in_ready !== 1'b1) begin
      miss_cnt++; $display("FAIL idle_in_ready got %b exp 1", bus_a.in_ready);
    end
  endtask

  task automatic test_basic;
    logic [8:0] vals [4];
    vals = '{9'd10, 9'd20, 9'd30, 9'd40};
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      {bus_a.in_cout, bus_a.in_sum} = vals[i];
      tick;
      vec_cnt++;
      if (bus_a.out_valid !== (i == 3)) begin
        miss_cnt++; $display("FAIL basic_valid[%0d] got %b exp %b", i, bus_a.out_valid, (i == 3));
      end
    end
    bus_a.in_valid = 1'b0;
    vec_cnt++;
    if (bus_a.out_data !== 16'd100 || bus_a.out_ovf !== 1'b0) begin
      miss_cnt++; $display("FAIL basic_data got %0d/%b exp 100/0", bus_a.out_data, bus_a.out_ovf);
    end
    tick;
    vec_cnt++;
    if (bus_a.out_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL basic_handoff got %b exp 0", bus_a.out_valid);
    end
  endtask

  task automatic test_max_value;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_sum   = 8'hFF;
      bus_a.in_cout  = 1'b1;
      tick;
    end
    bus_a.in_valid = 1'b0;
    vec_cnt++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'd2044 || bus_a.out_ovf !== 1'b0) begin
      miss_cnt++;
      $display("FAIL max_value got v=%b d=%0d o=%b exp 1/2044/0",
               bus_a.out_valid, bus_a.out_data, bus_a.out_ovf);
    end
    tick;
  endtask

  task automatic test_overflow;
    logic [9:0] exp_data;
`ifdef ACC_SAT_EN
    exp_data = 10'd1023;
`else
    exp_data = 10'd1020;
`endif
    bus_b.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_sum   = 8'hFF;
      bus_b.in_cout  = 1'b1;
      tick;
    end
    bus_b.in_valid = 1'b0;
    vec_cnt++;
    if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== exp_data || bus_b.out_ovf !== 1'b1) begin
      miss_cnt++;
      $display("FAIL ovf_block got v=%b d=%0d o=%b exp 1/%0d/1",
               bus_b.out_valid, bus_b.out_data, bus_b.out_ovf, exp_data);
    end
    tick;
    vec_cnt++;
    if (bus_b.out_valid !== 1'b0 || bus_b.out_ovf !== 1'b0) begin
      miss_cnt++;
      $display("FAIL ovf_clear got v=%b o=%b exp 0/0", bus_b.out_valid, bus_b.out_ovf);
    end
  endtask

  task automatic test_backpressure;
    bus_a.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus_a.in_valid = 1'b1;
      {bus_a.in_cout, bus_a.in_sum} = 9'(i);
      tick;
    end
    bus_a.in_sum = 8'd50;
    bus_a.in_cout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'd10) begin
        miss_cnt++;
        $display("FAIL stall[%0d] got r=%b v=%b d=%0d exp 0/1/10",
                 i, bus_a.in_ready, bus_a.out_valid, bus_a.out_data);
      end
      tick;
    end
    bus_a.out_ready = 1'b1;
    #1;
    vec_cnt++;
    if (bus_a.in_ready !== 1'b1) begin
      miss_cnt++; $display("FAIL release_in_ready got %b exp 1", bus_a.in_ready);
    end
    tick;
    vec_cnt++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 16'd50) begin
      miss_cnt++;
      $display("FAIL restart got v=%b d=%0d exp 0/50", bus_a.out_valid, bus_a.out_data);
    end
    // Three more accepts complete the block only if the restart counted as the first.
    for (int i = 1; i <= 3; i++) begin
      {bus_a.in_cout, bus_a.in_sum} = 9'(i);
      tick;
    end
    bus_a.in_valid = 1'b0;
    vec_cnt++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'd56) begin
      miss_cnt++;
      $display("FAIL restart_block got v=%b d=%0d exp 1/56", bus_a.out_valid, bus_a.out_data);
    end
    tick;
  endtask

  task automatic test_mid_reset;
    bus_a.out_ready = 1'b1;
    bus_a.in_valid  = 1'b1;
    {bus_a.in_cout, bus_a.in_sum} = 9'd5;
    tick;
    {bus_a.in_cout, bus_a.in_sum} = 9'd6;
    tick;
    #3;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b0 || bus_a.out_data !== 16'd0) begin
      miss_cnt++;
      $display("FAIL mid_reset got r=%b v=%b d=%0d exp 0/0/0",
               bus_a.in_ready, bus_a.out_valid, bus_a.out_data);
    end
    bus_a.in_valid = 1'b0;
    tick;
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus_a.in_valid = 1'b1;
      {bus_a.in_cout, bus_a.in_sum} = 9'(i);
      tick;
    end
    bus_a.in_valid = 1'b0;
    vec_cnt++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'd10) begin
      miss_cnt++;
      $display("FAIL post_reset got v=%b d=%0d exp 1/10", bus_a.out_valid, bus_a.out_data);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_seq [3];
    exp_seq = '{16'd7, 16'd8, 16'd9};
    bus_c.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_c.in_valid = 1'b1;
      {bus_c.in_cout, bus_c.in_sum} = exp_seq[i][8:0];
      tick;
      vec_cnt++;
      if (bus_c.out_valid !== 1'b1 || bus_c.out_data !== exp_seq[i]) begin
        miss_cnt++;
        $display("FAIL b2b[%0d] got v=%b d=%0d exp 1/%0d",
                 i, bus_c.out_valid, bus_c.out_data, exp_seq[i]);
      end
    end
    bus_c.in_valid = 1'b0;
    tick;
    vec_cnt++;
    if (bus_c.out_valid !== 1'b0) begin
      miss_cnt++; $display("FAIL b2b_drain got %b exp 0", bus_c.out_valid);
    end
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_sum = 8'd0; bus_a.in_cout = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_sum = 8'd0; bus_b.in_cout = 1'b0; bus_b.out_ready = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_sum = 8'd0; bus_c.in_cout = 1'b0; bus_c.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_max_value;
    test_overflow;
    test_backpressure;
    test_mid_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
